// File: rtl/rom_fetch_unit_if.sv
// Bundles the fetch request/response handshakes and the enable/busy ROM bus.
// master: the fetch unit's view; slave: the surrounding core/ROM view.
interface rom_fetch_unit_if #(
    parameter int unsigned addr_size = 8,
    parameter int unsigned word_size = 8,
    parameter int unsigned offset    = 2
);
    localparam int unsigned DW = word_size * (2 ** offset);

    logic                 req_valid;
    logic                 req_ready;
    logic [addr_size-1:0] req_addr;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [DW-1:0]        resp_data;
    logic                 resp_error;
    logic                 rom_enable;
    logic [addr_size-1:0] rom_addr;
    logic                 rom_busy;
    logic [DW-1:0]        rom_data;

    modport master (
        input  req_valid, req_addr, resp_ready, rom_busy, rom_data,
        output req_ready, resp_valid, resp_data, resp_error, rom_enable, rom_addr
    );

    modport slave (
        output req_valid, req_addr, resp_ready, rom_busy, rom_data,
        input  req_ready, resp_valid, resp_data, resp_error, rom_enable, rom_addr
    );
endinterface

// File: rtl/rom_fetch_unit.sv
// Requester-side controller for an enable/busy ROM: accepts line fetches, strobes the ROM,
// waits out its busy window and returns the line (or a timeout error) on a response channel.
module rom_fetch_unit #(
    parameter int unsigned addr_size      = 8,
    parameter int unsigned word_size      = 8,
    parameter int unsigned offset         = 2,
    parameter int unsigned timeout_cycles = 15
) (
    input logic                clock,
    input logic                reset_n,
    rom_fetch_unit_if.master   bus
);
    localparam int unsigned DW   = word_size * (2 ** offset);
    localparam int unsigned CntW = $clog2(timeout_cycles + 1);
    localparam logic [CntW-1:0]      CntMax    = CntW'(timeout_cycles);
    localparam logic [CntW-1:0]      CntLast   = CntW'(timeout_cycles - 1);
    localparam logic [addr_size-1:0] LineMask  = addr_size'((2 ** offset) - 1);

    typedef enum logic [2:0] {
        StIdle,
        StEnable,
        StWaitBusy,
        StWaitDone,
        StResp
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [addr_size-1:0] addr_q, addr_d;
    logic [DW-1:0]        data_q, data_d;
    logic                 err_q, err_d;

    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr & ~LineMask;
                    cnt_d   = '0;
                    state_d = StEnable;
                end
            end
            StEnable: state_d = StWaitBusy;
            StWaitBusy: begin
                cnt_d = cnt_inc;
                // Timeout wins over a same-cycle busy edge so the wait window is a hard bound.
                if (cnt_q == CntLast) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (bus.rom_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                cnt_d = cnt_inc;
                if (cnt_q == CntLast) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (!bus.rom_busy) begin
                    data_d  = bus.rom_data;
                    err_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // req_ready is gated by reset so it reads 0 while reset is held.
    assign bus.req_ready  = reset_n && (state_q == StIdle);
    assign bus.rom_enable = (state_q == StEnable);
    assign bus.resp_valid = (state_q == StResp);
    assign bus.rom_addr   = addr_q;
    assign bus.resp_data  = data_q;
    assign bus.resp_error = err_q;
endmodule
